// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared constants for the MIPS control path: opcode and funct codes,
//   ALU-control encodings, alu_src_b / pc_src select codes, the alu_op type
//   used between the FSM and the ALU decoder, and the 4-bit FSM state codes.
package mips_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Native 3-bit ALU-control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Operation request from the FSM to the ALU decoder. ALUOP_NONE is used in
  // states where the ALU is idle, so alu_control reads as all-zero there.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } alu_op_t;

  // FSM state codes (also exported on the debug state port)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;
  localparam logic [3:0] S_BRANCHNE = 4'd13;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder
//   Combinational ALU-control decoder for the multicycle control unit.
//   Ports:
//     alu_op      in  alu_op_t   : add / sub / decode funct / idle
//     funct       in  [5:0]      : instruction funct field
//     alu_control out [ALUCTRL_W]: zero-extended 3-bit ALU encoding
//   Unknown funct codes fall back to add without any flag.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  alu_op_t              alu_op,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] enc;

  always_comb begin
    // NOTE: default assignment first so every path drives enc -- no latch.
    enc = ALU_AND;
    unique case (alu_op)
      ALUOP_ADD: enc = ALU_ADD;
      ALUOP_SUB: enc = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  enc = ALU_SUB;
          FN_AND:  enc = ALU_AND;
          FN_OR:   enc = ALU_OR;
          FN_SLT:  enc = ALU_SLT;
          default: enc = ALU_ADD;
        endcase
      end
      ALUOP_NONE: enc = ALU_AND;
    endcase
  end

  assign alu_control = ALUCTRL_W'(enc);

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore FSM sequencing fetch / decode / execute / memory / writeback for
//   the multicycle MIPS datapath (shared memory, shared ALU).
//   Ports:
//     clk, reset (async, active-high)
//     opcode, funct     : IR fields; opcode is acted on in DECODE
//     zero              : ALU zero flag, feeds pc_en combinationally
//     mem_ready         : memory access complete (FETCH / MEMREAD / MEMWRITE)
//     iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//     alu_src_b, pc_src, pc_en, alu_control : datapath controls
//     illegal_op        : one-cycle pulse in ILLEGAL
//     state             : current state code, for debug
//   Build option: define MCU_BNE_EN to decode bne (000101) into BRANCHNE;
//   otherwise bne is trapped as an illegal opcode.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic                 pc_en,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal_op,
  output logic [3:0]           state
);

  logic [3:0] next_state;
  logic       is_store;   // lw/sw choice captured in DECODE for MEMADR
  logic       pc_write;
  logic       branch_eq;
  logic       branch_ne;
  alu_op_t    alu_op;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset returns the FSM to FETCH at once, aborting any pending access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MCU_BNE_EN
          OP_BNE:       next_state = S_BRANCHNE;
`endif
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEX:   next_state = S_ADDIWB;
      default:    next_state = S_FETCH;  // terminal states and unused codes
    endcase
  end

  // Moore output decode; mem_ready only gates the FETCH strobes and the
  // MEMWRITE write strobe, which stays up until the access is accepted.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    alu_op     = ALUOP_NONE;
    case (state)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = ~mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch_eq = 1'b1;
      end
`ifdef MCU_BNE_EN
      S_BRANCHNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch_ne = 1'b1;
      end
`endif
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch_eq & zero) | (branch_ne & ~zero);

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Randomized bench for multicycle_control_unit. A reference model turns each
//   instruction into its list of steps (spec state numbers) and predicts every
//   control output per cycle; two DUTs (ALUCTRL_W = 3 and 4) share stimulus.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, illegal_op;
  logic [2:0] alu_control;
  logic [3:0] state;

  logic       iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4, alu_src_a4;
  logic [1:0] alu_src_b4, pc_src4;
  logic       pc_en4, illegal_op4;
  logic [3:0] alu_control4;
  logic [3:0] state4;

  int n_checks = 0;
  int n_errors = 0;
  int steps_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
  );

  multicycle_control_unit #(.ALUCTRL_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord4), .mem_write(mem_write4), .ir_write(ir_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .pc_src(pc_src4), .pc_en(pc_en4),
    .alu_control(alu_control4), .illegal_op(illegal_op4), .state(state4)
  );

  wire [12:0] ctrl_obs  = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                           alu_src_a, alu_src_b, pc_src, pc_en, illegal_op};
  wire [12:0] ctrl_obs4 = {iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4,
                           alu_src_a4, alu_src_b4, pc_src4, pc_en4, illegal_op4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Step numbers follow the state list: 0 FETCH ... 13 BRANCHNE.
  task automatic build_steps(input logic [5:0] op);
    steps_q = {0, 1};
    case (op)
      6'b100011: steps_q = {steps_q, 2, 3, 4};
      6'b101011: steps_q = {steps_q, 2, 5};
      6'b000000: steps_q = {steps_q, 6, 7};
      6'b000100: steps_q.push_back(8);
      6'b001000: steps_q = {steps_q, 9, 10};
      6'b000010: steps_q.push_back(11);
`ifdef MCU_BNE_EN
      6'b000101: steps_q.push_back(13);
`endif
      default:   steps_q.push_back(12);
    endcase
  endtask

  function automatic int cpi(input logic [5:0] op);
    case (op)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      default:                         return 3;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input int s, input logic [5:0] fn);
    case (s)
      0, 1, 2, 9: return 4'd2;
      8, 13:      return 4'd6;
      6: case (fn)
           6'b100010: return 4'd6;
           6'b100100: return 4'd0;
           6'b100101: return 4'd1;
           6'b101010: return 4'd7;
           default:   return 4'd2;
         endcase
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [12:0] exp_ctrl(input int s, input logic rdy, input logic z);
    logic io, mw, irw, rd, m2r, rw, sa, pe, il;
    logic [1:0] sb, ps;
    {io, mw, irw, rd, m2r, rw, sa, pe, il} = '0;
    sb = 2'd0;
    ps = 2'd0;
    case (s)
      0:     begin sb = 2'd1; irw = rdy; pe = rdy; end
      1:     sb = 2'd3;
      2, 9:  begin sa = 1'b1; sb = 2'd2; end
      3:     io = 1'b1;
      4:     begin rw = 1'b1; m2r = 1'b1; end
      5:     begin io = 1'b1; mw = ~rdy; end
      6:     sa = 1'b1;
      7:     begin rd = 1'b1; rw = 1'b1; end
      8:     begin sa = 1'b1; ps = 2'd1; pe = z; end
      13:    begin sa = 1'b1; ps = 2'd1; pe = ~z; end
      10:    rw = 1'b1;
      11:    begin ps = 2'd2; pe = 1'b1; end
      12:    il = 1'b1;
      default: ;
    endcase
    return {io, mw, irw, rd, m2r, rw, sa, sb, ps, pe, il};
  endfunction

  // Run one instruction: fstall low-ready cycles in FETCH, mstall in
  // MEMREAD/MEMWRITE. zmode 0/1 forces zero, otherwise zero is random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fstall, input int mstall, input int zmode,
                           output int cycles, output int iord_n, output int wb_n);
    int s, n;
    logic rdy, z;
    cycles = 0;
    iord_n = 0;
    wb_n   = 0;
    opcode = op;
    funct  = fn;
    build_steps(op);
    for (int i = 0; i < steps_q.size(); i++) begin
      s = steps_q[i];
      n = (s == 0) ? fstall : ((s == 3 || s == 5) ? mstall : 0);
      for (int k = 0; k <= n; k++) begin
        if (s == 0 || s == 3 || s == 5) rdy = (k == n);
        else rdy = 1'($urandom_range(0, 1));
        z = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom_range(0, 1));
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        check("state",  32'(state),        32'(s));
        check("ctrl",   32'(ctrl_obs),     32'(exp_ctrl(s, rdy, z)));
        check("alu3",   32'(alu_control),  32'(exp_alu(s, fn)));
        check("state4", 32'(state4),       32'(s));
        check("ctrl4",  32'(ctrl_obs4),    32'(exp_ctrl(s, rdy, z)));
        check("alu4",   32'(alu_control4), 32'(exp_alu(s, fn)));
        cycles++;
        if (iord) iord_n++;
        if (reg_write && mem_to_reg) wb_n++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [5:0] op_list [8];
  logic [5:0] fn_list [6];

  initial begin
    int cyc, io_n, wb_n, fs, ms;
    logic [5:0] op, fn;
    op_list = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b111111};
    fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Reset state with mem_ready low
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl",  32'(ctrl_obs), 32'(exp_ctrl(0, 1'b0, 1'b0)));
    check("rst_alu",   32'(alu_control), 32'd2);
    @(posedge clk); #1;
    reset = 1'b0;

    // add: 0,1,6,7 then back to FETCH
    run_instr(6'b000000, 6'b100000, 0, 0, 2, cyc, io_n, wb_n);
    check("add_cpi", 32'(cyc), 32'd4);

    // lw with 2 stall cycles in MEMREAD
    run_instr(6'b100011, 6'b000000, 0, 2, 2, cyc, io_n, wb_n);
    check("lw_cycles", 32'(cyc), 32'd7);
    check("lw_iord",   32'(io_n), 32'd3);
    check("lw_wb",     32'(wb_n), 32'd1);

    // beq taken / not taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1, cyc, io_n, wb_n);
    run_instr(6'b000100, 6'b000000, 0, 0, 0, cyc, io_n, wb_n);
    check("beq_cpi", 32'(cyc), 32'd3);

    // illegal opcode, then bne (illegal unless built with the bne option)
    run_instr(6'b111111, 6'b000000, 0, 0, 2, cyc, io_n, wb_n);
    run_instr(6'b000101, 6'b000000, 0, 0, 0, cyc, io_n, wb_n);
    run_instr(6'b000101, 6'b000000, 0, 0, 1, cyc, io_n, wb_n);

    // slt, and sw with fetch and write stalls
    run_instr(6'b000000, 6'b101010, 0, 0, 2, cyc, io_n, wb_n);
    run_instr(6'b101011, 6'b000000, 2, 3, 2, cyc, io_n, wb_n);
    check("sw_cycles", 32'(cyc), 32'd9);

    // Async reset in the middle of a stalled MEMWRITE
    opcode = 6'b101011; funct = '0; zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check("mw_state",   32'(state), 32'd5);
    check("mw_active",  32'(mem_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mw_abort",   32'(mem_write), 32'd0);
    check("mw_rst_st",  32'(state), 32'd0);
    check("mw_rst_io",  32'(iord), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized instruction stream
    for (int t = 0; t < 300; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 5)];
      fs = $urandom_range(0, 2);
      ms = $urandom_range(0, 2);
      run_instr(op, fn, fs, ms, 2, cyc, io_n, wb_n);
      check("rand_cpi", 32'(cyc),
            32'(cpi(op) + fs + ((op == 6'b100011 || op == 6'b101011) ? ms : 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
